line_byte_tx: RTL and testbench

//  Host-facing transmitter for one memory line: captures a num_bits-wide line

---
 rtl/line_byte_tx_if.sv | 28 ++
 rtl/line_byte_tx.sv | 125 ++++++++++++
 tb/tb_line_byte_tx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/line_byte_tx_if.sv
// Host-side bundle for line_byte_tx: line load request plus the byte valid/ready stream.
// The slave modport is the transmitter; the master modport is whoever feeds lines and drains bytes.
interface line_byte_tx_if #(
  parameter int num_bits = 512
);
  localparam int NUM_BYTES = num_bits / 8;
  localparam int IDX_W     = $clog2(NUM_BYTES + 1);

  logic [num_bits-1:0] line_in;
  logic                line_load;
  logic                load_drop;
  logic                busy;
  logic [7:0]          byte_out;
  logic                byte_valid;
  logic                byte_ready;
  logic [IDX_W-1:0]    byte_idx;
  logic                line_done;

  modport master (
    output line_in, line_load, byte_ready,
    input  load_drop, busy, byte_out, byte_valid, byte_idx, line_done
  );

  modport slave (
    input  line_in, line_load, byte_ready,
    output load_drop, busy, byte_out, byte_valid, byte_idx, line_done
  );
endinterface

// File: rtl/line_byte_tx.sv
// Captures one BRAM line and streams it to the host byte-by-byte, byte 0 first.
// Optional LINE_CHECKSUM_EN appends one XOR-of-all-bytes checksum byte after the line.
module line_byte_tx #(
  parameter int num_bits = 512
) (
  input logic           clk,
  input logic           rst,
  line_byte_tx_if.slave bus
);
  localparam int NUM_BYTES = num_bits / 8;
  localparam int IDX_W     = $clog2(NUM_BYTES + 1);
  localparam int SEL_W     = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

`ifdef LINE_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  state_t                       state, state_n;
  logic [NUM_BYTES-1:0][7:0]    shadow, shadow_n;
  logic [IDX_W-1:0]             idx, idx_n;
  logic                         drop_q, drop_n;
  logic                         done_q, done_n;
  logic                         valid;
  logic                         handshake;
  logic [7:0]                   cur_byte;
`ifdef LINE_CHECKSUM_EN
  logic [7:0]                   acc, acc_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shadow <= '0;
      idx    <= '0;
      drop_q <= 1'b0;
      done_q <= 1'b0;
`ifdef LINE_CHECKSUM_EN
      acc    <= '0;
`endif
    end else begin
      state  <= state_n;
      shadow <= shadow_n;
      idx    <= idx_n;
      drop_q <= drop_n;
      done_q <= done_n;
`ifdef LINE_CHECKSUM_EN
      acc    <= acc_n;
`endif
    end
  end

  // Any load seen outside IDLE is refused and reported one cycle later.
  always_comb begin
    state_n   = state;
    shadow_n  = shadow;
    idx_n     = idx;
    drop_n    = 1'b0;
    done_n    = 1'b0;
    valid     = (state != IDLE);
    handshake = valid & bus.byte_ready;
    cur_byte  = 8'h00;
`ifdef LINE_CHECKSUM_EN
    acc_n     = acc;
`endif

    case (state)
      IDLE: begin
        if (bus.line_load) begin
          shadow_n = bus.line_in;
          idx_n    = '0;
          state_n  = SEND;
`ifdef LINE_CHECKSUM_EN
          acc_n    = '0;
`endif
        end
      end
      SEND: begin
        cur_byte = shadow[idx[SEL_W-1:0]];
        drop_n   = bus.line_load;
        if (handshake) begin
`ifdef LINE_CHECKSUM_EN
          acc_n = acc ^ cur_byte;
`endif
          if (idx == LAST_IDX) begin
`ifdef LINE_CHECKSUM_EN
            state_n = CSUM;
            idx_n   = IDX_W'(NUM_BYTES);
`else
            state_n = IDLE;
            idx_n   = '0;
            done_n  = 1'b1;
`endif
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
`ifdef LINE_CHECKSUM_EN
      CSUM: begin
        cur_byte = acc;
        drop_n   = bus.line_load;
        if (handshake) begin
          state_n = IDLE;
          idx_n   = '0;
          done_n  = 1'b1;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  assign bus.byte_valid = valid;
  assign bus.busy       = valid;
  assign bus.byte_out   = cur_byte;
  assign bus.byte_idx   = idx;
  assign bus.load_drop  = drop_q;
  assign bus.line_done  = done_q;
endmodule

// File: tb/tb_line_byte_tx.sv
// Directed bench for line_byte_tx: a vector table for reset/stall/drop basics,
// then hand-written full-line sequences (full rate, toggled ready, drops, reset abort, checksum).
module tb_line_byte_tx;
  localparam int NB = 512;
  localparam int NUM_BYTES = NB / 8;
`ifdef LINE_CHECKSUM_EN
  localparam int TOTAL = NUM_BYTES + 1;
`else
  localparam int TOTAL = NUM_BYTES;
`endif

  typedef struct {
    bit         rst;
    bit         load;
    bit         ready;
    int         pat;
    bit         e_valid;
    bit         e_busy;
    int         e_idx;
    logic [7:0] e_byte;
    bit         e_done;
    bit         e_drop;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[10];

  line_byte_tx_if #(.num_bits(NB)) bus ();

  line_byte_tx #(.num_bits(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Pattern 0: byte k = k; 1: all 0xFF; 2: 0x5A then 0xA5; 3: distractor line.
  function automatic logic [NB-1:0] make_line(input int pat);
    logic [NB-1:0] l;
    l = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      case (pat)
        0:       l[8*k +: 8] = 8'(k);
        1:       l[8*k +: 8] = 8'hFF;
        2:       l[8*k +: 8] = (k == 0) ? 8'h5A : 8'hA5;
        default: l[8*k +: 8] = 8'h3C ^ 8'(k);
      endcase
    end
    return l;
  endfunction

  function automatic logic [7:0] exp_byte(input int pat, input int k);
    if (k == NUM_BYTES) begin
      case (pat)
        2:       return 8'hFF;
        default: return 8'h00;
      endcase
    end
    case (pat)
      0:       return 8'(k);
      1:       return 8'hFF;
      2:       return (k == 0) ? 8'h5A : 8'hA5;
      default: return 8'h3C ^ 8'(k);
    endcase
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output(input string tag, input bit v, input bit b, input int idx,
                              input logic [7:0] byt, input bit d, input bit dr);
    check_val({tag, ".byte_valid"}, 32'(bus.byte_valid), 32'(v));
    check_val({tag, ".busy"},       32'(bus.busy),       32'(b));
    check_val({tag, ".byte_idx"},   32'(bus.byte_idx),   32'(idx));
    check_val({tag, ".byte_out"},   32'(bus.byte_out),   32'(byt));
    check_val({tag, ".line_done"},  32'(bus.line_done),  32'(d));
    check_val({tag, ".load_drop"},  32'(bus.load_drop),  32'(dr));
  endtask

  task automatic apply_stimulus(input vec_t v);
    rst            = v.rst;
    bus.line_load  = v.load;
    bus.byte_ready = v.ready;
    bus.line_in    = make_line(v.pat);
  endtask

  task automatic start_line(input int pat);
    bus.line_in    = make_line(pat);
    bus.line_load  = 1'b1;
    bus.byte_ready = 1'b1;
    @(negedge clk);
    bus.line_load  = 1'b0;
  endtask

  // Entered at the negedge where byte 0 should be on the port.
  task automatic run_stream(input string tag, input int pat, input bit toggle, input int drop_idx);
    int k = 0;
    int cyc = 0;
    bit rdy = 1'b1;
    bit prev_load = 1'b0;
    bit ld;
    while (k < TOTAL && cyc < 400) begin
      check_output($sformatf("%s.k%0d", tag, k), 1'b1, 1'b1, k, exp_byte(pat, k), 1'b0, prev_load);
      ld = (drop_idx >= 0) && rdy && (k == drop_idx || k == TOTAL - 1);
      bus.byte_ready = rdy;
      bus.line_load  = ld;
      if (ld) bus.line_in = make_line(3);
      @(negedge clk);
      cyc++;
      prev_load = ld;
      if (rdy) k++;
      if (toggle) rdy = !rdy;
    end
    if (cyc >= 400) begin
      errors++;
      $display("[TB] FAIL %s.timeout: got %0d bytes, expected %0d", tag, k, TOTAL);
    end
    check_output({tag, ".end"}, 1'b0, 1'b0, 0, 8'h00, 1'b1, prev_load);
    bus.line_load = 1'b0;
    @(negedge clk);
    check_output({tag, ".after"}, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    // rst load ready pat | valid busy idx byte done drop
    vecs[0] = '{1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1, 0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b1, 1, 8'h01, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b1, 2, 8'h02, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_output($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_busy, vecs[i].e_idx,
                   vecs[i].e_byte, vecs[i].e_done, vecs[i].e_drop);
    end
    bus.line_load = 1'b0;
    rst = 1'b0;

    $display("[TB] full-rate line");
    start_line(0);
    run_stream("full", 0, 1'b0, -1);

    $display("[TB] toggled ready");
    start_line(0);
    run_stream("toggle", 0, 1'b1, -1);

    $display("[TB] loads while busy");
    start_line(0);
    run_stream("drop", 0, 1'b0, 10);

    // Reset must abort the line mid-stream without a line_done.
    $display("[TB] reset mid-line");
    start_line(0);
    for (int k = 0; k <= 20; k++) begin
      check_output($sformatf("abort.k%0d", k), 1'b1, 1'b1, k, exp_byte(0, k), 1'b0, 1'b0);
      bus.byte_ready = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check_output("abort.rst", 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_output("abort.idle", 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    start_line(1);
    run_stream("restart", 1, 1'b0, -1);

    $display("[TB] checksum pattern");
    start_line(2);
    run_stream("csum", 2, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
